// File: rtl/stall_flush_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
package stall_flush_ctrl_pkg;

  typedef enum logic [0:0] {
    Run,
    DropFetch
  } pipe_ctrl_state_e;

  typedef struct packed {
    logic load_pc;
    logic load_ifid;
    logic load_idex;
    logic load_exmem;
    logic load_memwb;
    logic flush_ifid;
    logic flush_idex;
    logic bubble_idex;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CtrlReset    = '{load_pc: 1'b0, load_ifid: 1'b0, load_idex: 1'b0,
                                          load_exmem: 1'b0, load_memwb: 1'b0, flush_ifid: 1'b1,
                                          flush_idex: 1'b1, bubble_idex: 1'b0};
  localparam pipe_ctrl_t CtrlRun      = '{load_pc: 1'b1, load_ifid: 1'b1, load_idex: 1'b1,
                                          load_exmem: 1'b1, load_memwb: 1'b1, flush_ifid: 1'b0,
                                          flush_idex: 1'b0, bubble_idex: 1'b0};
  localparam pipe_ctrl_t CtrlHold     = '{load_pc: 1'b0, load_ifid: 1'b0, load_idex: 1'b0,
                                          load_exmem: 1'b0, load_memwb: 1'b0, flush_ifid: 1'b0,
                                          flush_idex: 1'b0, bubble_idex: 1'b0};
  localparam pipe_ctrl_t CtrlRedirect = '{load_pc: 1'b1, load_ifid: 1'b1, load_idex: 1'b1,
                                          load_exmem: 1'b1, load_memwb: 1'b1, flush_ifid: 1'b1,
                                          flush_idex: 1'b1, bubble_idex: 1'b0};
  localparam pipe_ctrl_t CtrlBubble   = '{load_pc: 1'b0, load_ifid: 1'b0, load_idex: 1'b1,
                                          load_exmem: 1'b1, load_memwb: 1'b1, flush_ifid: 1'b0,
                                          flush_idex: 1'b0, bubble_idex: 1'b1};
  // Fetch not usable: hold PC, let IF/ID capture a NOP, keep the back end moving.
  localparam pipe_ctrl_t CtrlFetchNop = '{load_pc: 1'b0, load_ifid: 1'b1, load_idex: 1'b1,
                                          load_exmem: 1'b1, load_memwb: 1'b1, flush_ifid: 1'b1,
                                          flush_idex: 1'b0, bubble_idex: 1'b0};

endpackage

// File: rtl/stall_flush_ctrl_if.sv
// Hazard/handshake inputs and per-stage pipeline controls.
interface stall_flush_ctrl_if;
  logic lu_hazard;
  logic redirect;
  logic imem_req;
  logic imem_resp;
  logic dmem_req;
  logic dmem_resp;
  logic load_pc;
  logic load_ifid;
  logic load_idex;
  logic load_exmem;
  logic load_memwb;
  logic flush_ifid;
  logic flush_idex;
  logic bubble_idex;

  // Datapath side: reports hazards, consumes controls.
  modport master (
    output lu_hazard, redirect, imem_req, imem_resp, dmem_req, dmem_resp,
    input  load_pc, load_ifid, load_idex, load_exmem, load_memwb,
    input  flush_ifid, flush_idex, bubble_idex
  );

  // Controller side.
  modport slave (
    input  lu_hazard, redirect, imem_req, imem_resp, dmem_req, dmem_resp,
    output load_pc, load_ifid, load_idex, load_exmem, load_memwb,
    output flush_ifid, flush_idex, bubble_idex
  );
endinterface

// File: rtl/stall_flush_ctrl_stall_watchdog.sv
// Consecutive-stall counter with a sticky timeout flag.
module stall_watchdog #(
  parameter int unsigned WDT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  output logic timeout
);

  localparam int unsigned CntW = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(WDT_CYCLES - 1);

  logic [CntW-1:0] count_q, count_d;
  logic            timeout_q, timeout_d;
  logic            at_limit;

  // Count and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  // Count saturates at the limit; flag sets on a stall seen at the limit and never clears.
  always_comb begin
    at_limit  = (count_q == Limit);
    count_d   = count_q;
    timeout_d = timeout_q | (stall & at_limit);
    if (!stall) begin
      count_d = '0;
    end else if (!at_limit) begin
      count_d = count_q + CntW'(1);
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/stall_flush_ctrl.sv
// Pipeline stall/flush responder: priority mux, wrong-path fetch FSM, watchdog, stall counter.
module stall_flush_ctrl #(
  parameter int unsigned WDT_CYCLES = 1024,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  stall_flush_ctrl_if.slave    bus,
  output logic                 stall_timeout,
  output logic [CNT_W-1:0]     perf_stall_cnt
);
  import stall_flush_ctrl_pkg::*;

  pipe_ctrl_state_e state_q, state_d;
  pipe_ctrl_t       ctrl;
  logic             dmem_stall, fetch_stall;
  logic [CNT_W-1:0] perf_q, perf_d;

  assign dmem_stall  = bus.dmem_req & ~bus.dmem_resp;
  assign fetch_stall = bus.imem_req & ~bus.imem_resp;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= Run;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. A data stall freezes everything, including the FSM.
  always_comb begin
    state_d = state_q;
    if (!dmem_stall) begin
      if (bus.redirect) begin
        // A redirect while already dropping keeps dropping.
        if (state_q == Run && fetch_stall) begin
          state_d = DropFetch;
        end
      end else if (state_q == DropFetch && bus.imem_resp) begin
        state_d = Run;
      end
    end
  end

  // Output priority mux.
  always_comb begin
    ctrl = CtrlRun;
    if (rst) begin
      ctrl = CtrlReset;
    end else if (dmem_stall) begin
      ctrl = CtrlHold;
    end else if (bus.redirect) begin
      ctrl = CtrlRedirect;
    end else if (bus.lu_hazard) begin
      ctrl = CtrlBubble;
      // The outstanding wrong-path word must still never reach IF/ID.
      if (state_q == DropFetch) begin
        ctrl.flush_ifid = 1'b1;
      end
    end else if (state_q == DropFetch || fetch_stall) begin
      ctrl = CtrlFetchNop;
    end
  end

  assign bus.load_pc     = ctrl.load_pc;
  assign bus.load_ifid   = ctrl.load_ifid;
  assign bus.load_idex   = ctrl.load_idex;
  assign bus.load_exmem  = ctrl.load_exmem;
  assign bus.load_memwb  = ctrl.load_memwb;
  assign bus.flush_ifid  = ctrl.flush_ifid;
  assign bus.flush_idex  = ctrl.flush_idex;
  assign bus.bubble_idex = ctrl.bubble_idex;

  // Saturating count of cycles where the PC did not advance.
  always_comb begin
    perf_d = perf_q;
    if (!ctrl.load_pc && perf_q != '1) begin
      perf_d = perf_q + CNT_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cnt = perf_q;

  stall_watchdog #(
    .WDT_CYCLES (WDT_CYCLES)
  ) u_stall_watchdog (
    .clk     (clk),
    .rst     (rst),
    .stall   (dmem_stall | fetch_stall),
    .timeout (stall_timeout)
  );

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// Directed bench for stall_flush_ctrl with a small watchdog and a narrow stall counter.
module tb_stall_flush_ctrl;

  localparam int unsigned WdtCycles = 8;
  localparam int unsigned CntW      = 4;

  // {load_pc, load_ifid, load_idex, load_exmem, load_memwb, flush_ifid, flush_idex, bubble_idex}
  localparam logic [7:0] ExpRst   = 8'b00000_110;
  localparam logic [7:0] ExpNorm  = 8'b11111_000;
  localparam logic [7:0] ExpHaz   = 8'b00111_001;
  localparam logic [7:0] ExpHazDf = 8'b00111_101;
  localparam logic [7:0] ExpFetch = 8'b01111_100;
  localparam logic [7:0] ExpDstl  = 8'b00000_000;
  localparam logic [7:0] ExpRedir = 8'b11111_110;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall_timeout;
  logic [CntW-1:0] perf_stall_cnt;
  logic [7:0]      obs_ctrl;
  int              total = 0;
  int              bad = 0;
  int              exp_cnt = 0;

  stall_flush_ctrl_if bus ();

  stall_flush_ctrl #(
    .WDT_CYCLES (WdtCycles),
    .CNT_W      (CntW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .stall_timeout  (stall_timeout),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  assign obs_ctrl = {bus.load_pc, bus.load_ifid, bus.load_idex, bus.load_exmem, bus.load_memwb,
                     bus.flush_ifid, bus.flush_idex, bus.bubble_idex};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic h, input logic rd, input logic ir, input logic ip,
                       input logic dr, input logic dp);
    bus.lu_hazard = h;
    bus.redirect  = rd;
    bus.imem_req  = ir;
    bus.imem_resp = ip;
    bus.dmem_req  = dr;
    bus.dmem_resp = dp;
  endtask

  // Check one cycle mid-period, then advance past the next rising edge.
  task automatic step(input string tag, input logic [7:0] exp_ctrl, input logic exp_to);
    #4;
    chk($sformatf("%s.ctrl", tag), 32'(obs_ctrl), 32'(exp_ctrl));
    chk($sformatf("%s.cnt", tag), 32'(perf_stall_cnt), 32'(exp_cnt));
    chk($sformatf("%s.timeout", tag), 32'(stall_timeout), 32'(exp_to));
    if (rst) begin
      exp_cnt = 0;
    end else if (!exp_ctrl[7] && exp_cnt < 15) begin
      exp_cnt = exp_cnt + 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // Reset for two cycles, then normal running.
    step("rst0", ExpRst, 0);
    step("rst1", ExpRst, 0);
    rst = 1'b0;
    step("run", ExpNorm, 0);

    // Single-cycle load-use hazard.
    drive(1, 0, 0, 0, 0, 0);
    step("haz", ExpHaz, 0);
    drive(0, 0, 0, 0, 0, 0);
    step("haz_end", ExpNorm, 0);

    // Data stall outranks a pending redirect; redirect acts when the stall clears.
    drive(0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step($sformatf("dstl%0d", i), ExpDstl, 0);
    drive(0, 1, 0, 0, 1, 1);
    step("dstl_resp", ExpRedir, 0);
    drive(0, 0, 0, 0, 0, 0);
    step("dstl_after", ExpNorm, 0);

    // Redirect with an outstanding fetch enters DropFetch.
    drive(0, 1, 1, 0, 0, 0);
    step("df_redir", ExpRedir, 0);
    drive(0, 0, 0, 0, 0, 0);
    step("df_idle", ExpFetch, 0);
    drive(1, 0, 1, 0, 0, 0);
    step("df_haz", ExpHazDf, 0);
    drive(0, 0, 1, 0, 0, 0);
    step("df_wait", ExpFetch, 0);
    drive(0, 0, 1, 1, 0, 0);
    step("df_resp", ExpFetch, 0);
    drive(0, 0, 0, 0, 0, 0);
    step("df_exit", ExpNorm, 0);

    // Redirect beats a simultaneous load-use hazard.
    drive(1, 1, 0, 0, 0, 0);
    step("redir_haz", ExpRedir, 0);
    drive(0, 0, 0, 0, 0, 0);
    step("redir_haz_end", ExpNorm, 0);

    // Watchdog: eight stall cycles, flag visible on the ninth and sticky afterwards.
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step($sformatf("wdt%0d", i), ExpDstl, 0);
    drive(0, 0, 0, 0, 0, 0);
    step("wdt_set", ExpNorm, 1);
    step("wdt_hold", ExpNorm, 1);

    // Plain fetch stall long enough to saturate the stall counter.
    drive(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) step($sformatf("sat%0d", i), ExpFetch, 1);
    drive(0, 0, 0, 0, 0, 0);
    step("sat_end", ExpNorm, 1);

    // Reset clears the sticky flag and the counter.
    rst = 1'b1;
    step("rst2", ExpRst, 1);
    rst = 1'b0;
    step("post_rst", ExpNorm, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
